// File: rtl/a2bus_capture_pkg.sv
// rtl/a2bus_capture_pkg.sv - shared event type and address-window helper for the bus capture block
package a2bus_capture_pkg;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        rw_n;
  } a2bus_event_t;

  function automatic logic addr_in_window(input logic [15:0] addr,
                                          input logic [15:0] lo,
                                          input logic [15:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - single-clock first-word-fall-through FIFO with occupancy count
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     clear_i,
  input  logic                     push_valid_i,
  input  logic [WIDTH-1:0]         push_data_i,
  output logic                     push_ready_o,
  output logic                     pop_valid_o,
  input  logic                     pop_ready_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop, full;

  assign full        = (count_q == CNT_FULL);
  assign pop_valid_o = (count_q != '0);
  assign count_o     = count_q;
  // Gate the head with valid so an empty queue never exposes stale storage.
  assign pop_data_o  = pop_valid_o ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    do_pop       = pop_valid_o && pop_ready_i;
    push_ready_o = !full || do_pop;
    do_push      = push_valid_i && push_ready_o;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/a2bus_write_capture.sv
// rtl/a2bus_write_capture.sv - filters latched Apple II bus cycles into a FWFT event queue
module a2bus_write_capture
  import a2bus_capture_pkg::*;
#(
  parameter int          DEPTH         = 16,
  parameter logic [15:0] ADDR_LO       = 16'h0400,
  parameter logic [15:0] ADDR_HI       = 16'h0BFF,
  parameter bit          CAPTURE_READS = 1'b0,
  parameter bit          MAIN_ONLY     = 1'b1
) (
  input  logic                       clk_logic_i,
  input  logic                       system_reset_n_i,
  input  logic                       enable_i,
  input  logic                       clear_i,
  input  logic [15:0]                addr_i,
  input  logic [7:0]                 data_i,
  input  logic                       rw_n_i,
  input  logic                       m2sel_n_i,
  input  logic                       data_in_strobe_i,
  output logic                       pop_valid_o,
  input  logic                       pop_ready_i,
  output logic [15:0]                pop_addr_o,
  output logic [7:0]                 pop_data_o,
  output logic                       pop_rw_n_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o,
  output logic [15:0]                drop_count_o
);
  a2bus_event_t ev_in, ev_head;
  logic         match, push_ready, drop;
  logic         overflow_q, overflow_d;
  logic [15:0]  drop_count_q, drop_count_d;

  assign ev_in = '{addr: addr_i, data: data_i, rw_n: rw_n_i};

  assign match = data_in_strobe_i && enable_i
              && addr_in_window(addr_i, ADDR_LO, ADDR_HI)
              && (!rw_n_i || CAPTURE_READS)
              && (!MAIN_ONLY || !m2sel_n_i);

  sync_fifo_fwft #(
    .WIDTH ($bits(a2bus_event_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i        (clk_logic_i),
    .rst_n_i      (system_reset_n_i),
    .clear_i      (clear_i),
    .push_valid_i (match),
    .push_data_i  (ev_in),
    .push_ready_o (push_ready),
    .pop_valid_o  (pop_valid_o),
    .pop_ready_i  (pop_ready_i),
    .pop_data_o   (ev_head),
    .count_o      (count_o)
  );

  assign pop_addr_o = ev_head.addr;
  assign pop_data_o = ev_head.data;
  assign pop_rw_n_o = ev_head.rw_n;

  // A match lost to clear is intentionally not counted as a drop.
  assign drop = match && !push_ready && !clear_i;

  always_comb begin
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    if (clear_i) begin
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_logic_i or negedge system_reset_n_i) begin
    if (!system_reset_n_i) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign overflow_o   = overflow_q;
  assign drop_count_o = drop_count_q;

endmodule
